// File: rtl/ok_wire_in_queue_pkg.sv
// Shared widths and types for the Wire In endpoint and its commit queue.
package ok_wire_pkg;
  localparam int OK_ADDR_W = 8;
  localparam int OK_DATA_W = 32;
  typedef logic [OK_DATA_W-1:0] ok_word_t;
  typedef logic [OK_ADDR_W-1:0] ok_addr_t;
endpackage

// File: rtl/ok_wire_in_queue_if.sv
// Host write bus plus the user-side queue handshake of the Wire In endpoint.
interface ok_wire_in_queue_if;
  import ok_wire_pkg::*;
  logic     ti_write;
  logic     ti_wireupdate;
  ok_addr_t ti_addr;
  ok_word_t ti_datain;
  logic     q_valid;
  logic     q_ready;
  ok_word_t q_data;

  modport master (
    output ti_write, ti_wireupdate, ti_addr, ti_datain, q_ready,
    input  q_valid, q_data
  );
  modport slave (
    input  ti_write, ti_wireupdate, ti_addr, ti_datain, q_ready,
    output q_valid, q_data
  );
endinterface

// File: rtl/ok_wire_in_queue_fifo.sv
// DEPTH x 32 synchronous FIFO with show-ahead head; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module ok_wire_fifo
  import ok_wire_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          ti_clk,
  input  logic          ti_reset,
  input  logic          push,
  input  logic          pop,
  input  ok_word_t      wdata,
  output ok_word_t      head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  ok_word_t      mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  // Head reads as zero while empty so q_data is clean after reset.
  assign head  = empty ? '0 : mem[rptr];

  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ti_clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/ok_wire_in_queue.sv
// Host-to-FPGA Wire In endpoint: stages writes, commits on wireupdate, queues commits.
// Optional WIRE_IN_CHANGE_ONLY_EN: queue a commit only when the value actually changes.
module ok_wire_in_queue
  import ok_wire_pkg::*;
#(
  parameter int       DEPTH       = 8,
  parameter ok_word_t RESET_VALUE = 32'h0
) (
  input  logic                         ti_clk,
  input  logic                         ti_reset,
  ok_wire_in_queue_if.slave            bus,
  input  ok_addr_t                     ep_addr,
  output ok_word_t                     ep_dataout,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         q_overflow,
  input  logic                         ovf_clr
);
  localparam int CW = $clog2(DEPTH + 1);

  ok_word_t stage;
  logic     dirty;
  logic     hit;
  logic     changed;
  logic     push;
  logic     pop;
  logic     full;
  logic     empty;
  ok_word_t head;

  assign hit = bus.ti_write && (bus.ti_addr == ep_addr);
`ifdef WIRE_IN_CHANGE_ONLY_EN
  assign changed = (stage != ep_dataout);
`else
  assign changed = 1'b1;
`endif
  assign push = bus.ti_wireupdate && dirty && changed;
  assign pop  = bus.q_ready && !empty;

  assign bus.q_valid = !empty;
  assign bus.q_data  = head;

  // A write landing with wireupdate commits the old stage and leaves the new one dirty.
  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) begin
      stage      <= RESET_VALUE;
      dirty      <= 1'b0;
      ep_dataout <= RESET_VALUE;
      q_overflow <= 1'b0;
    end else begin
      if (hit) begin
        stage <= bus.ti_datain;
        dirty <= 1'b1;
      end else if (bus.ti_wireupdate) begin
        dirty <= 1'b0;
      end
      if (bus.ti_wireupdate) ep_dataout <= stage;
      if (push && full && !pop) q_overflow <= 1'b1;
      else if (ovf_clr)         q_overflow <= 1'b0;
    end
  end

  ok_wire_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .ti_clk   (ti_clk),
    .ti_reset (ti_reset),
    .push     (push),
    .pop      (pop),
    .wdata    (stage),
    .head     (head),
    .count    (q_count),
    .full     (full),
    .empty    (empty)
  );
endmodule

// File: tb/tb_ok_wire_in_queue.sv
// Directed bench for ok_wire_in_queue with a scoreboard of expected queue pops.
module tb_ok_wire_in_queue;
  import ok_wire_pkg::*;

  localparam int DEPTH = 8;
  localparam ok_addr_t EP = 8'h3C;

  logic     ti_clk;
  logic     ti_reset;
  ok_word_t ep_dataout;
  logic [3:0] q_count;
  logic     q_overflow;
  logic     ovf_clr;
  ok_addr_t ep_addr;

  ok_wire_in_queue_if bus ();

  ok_wire_in_queue #(.DEPTH(DEPTH), .RESET_VALUE(32'h0)) dut (
    .ti_clk     (ti_clk),
    .ti_reset   (ti_reset),
    .bus        (bus.slave),
    .ep_addr    (ep_addr),
    .ep_dataout (ep_dataout),
    .q_count    (q_count),
    .q_overflow (q_overflow),
    .ovf_clr    (ovf_clr)
  );

  int checks = 0;
  int errors = 0;
  ok_word_t exp_q[$];

  initial ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every head the DUT hands over must match the scoreboard front.
  always @(negedge ti_clk) begin
    if (!ti_reset && bus.q_valid && bus.q_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%08h expected no entry", bus.q_data);
      end else begin
        ok_word_t e;
        e = exp_q.pop_front();
        if (bus.q_data !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%08h expected 0x%08h", bus.q_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic wr(input ok_addr_t a, input ok_word_t d);
    bus.ti_write = 1'b1; bus.ti_addr = a; bus.ti_datain = d;
    tick();
    bus.ti_write = 1'b0;
  endtask

  task automatic commit();
    bus.ti_wireupdate = 1'b1;
    tick();
    bus.ti_wireupdate = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.q_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q_count == 0) break;
      tick();
    end
    bus.q_ready = 1'b0;
    check({name, "_count"}, 32'(q_count), 32'd0);
    check({name, "_valid"}, 32'(bus.q_valid), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ti_reset = 1'b1;
    ep_addr = EP;
    ovf_clr = 1'b0;
    bus.ti_write = 1'b0; bus.ti_wireupdate = 1'b0;
    bus.ti_addr = '0; bus.ti_datain = '0; bus.q_ready = 1'b0;
    repeat (3) @(posedge ti_clk);
    #1;
    check("rst_dataout", ep_dataout, 32'h0);
    check("rst_valid", 32'(bus.q_valid), 32'd0);
    check("rst_qdata", bus.q_data, 32'h0);
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_ovf", 32'(q_overflow), 32'd0);
    @(negedge ti_clk);
    ti_reset = 1'b0;
    tick();

    // 1: basic write and commit
    wr(EP, 32'hA5A5_0001);
    commit(); exp_q.push_back(32'hA5A5_0001);
    check("t1_dataout", ep_dataout, 32'hA5A5_0001);
    check("t1_valid", 32'(bus.q_valid), 32'd1);
    check("t1_count", 32'(q_count), 32'd1);
    check("t1_qdata", bus.q_data, 32'hA5A5_0001);
    drain("t1_drain");

    // 2: write to another endpoint, commit is not dirty
    wr(EP + 8'd1, 32'h1234_5678);
    commit();
    check("t2_dataout", ep_dataout, 32'hA5A5_0001);
    check("t2_count", 32'(q_count), 32'd0);

    // 3: nine commits into an eight-deep queue
    for (int i = 0; i < 9; i++) begin
      wr(EP, 32'(i));
      commit();
      if (i < DEPTH) exp_q.push_back(32'(i));
    end
    check("t3_count", 32'(q_count), 32'd8);
    check("t3_ovf", 32'(q_overflow), 32'd1);
    check("t3_dataout", ep_dataout, 32'd8);

    // 4: full with simultaneous pop and push
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(q_overflow), 32'd0);
    wr(EP, 32'd100);
    bus.ti_wireupdate = 1'b1; bus.q_ready = 1'b1;
    tick();
    bus.ti_wireupdate = 1'b0; bus.q_ready = 1'b0;
    exp_q.push_back(32'd100);
    check("t4_count", 32'(q_count), 32'd8);
    check("t4_ovf", 32'(q_overflow), 32'd0);

    // overflow and ovf_clr in the same cycle: set wins
    wr(EP, 32'd200);
    bus.ti_wireupdate = 1'b1; ovf_clr = 1'b1;
    tick();
    bus.ti_wireupdate = 1'b0; ovf_clr = 1'b0;
    check("t4_set_wins", 32'(q_overflow), 32'd1);
    check("t4_count_hold", 32'(q_count), 32'd8);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    drain("t4_drain");

    // 5: write with wireupdate in the same cycle commits the old stage
    wr(EP, 32'h11);
    bus.ti_write = 1'b1; bus.ti_addr = EP; bus.ti_datain = 32'h22; bus.ti_wireupdate = 1'b1;
    tick();
    bus.ti_write = 1'b0; bus.ti_wireupdate = 1'b0;
    exp_q.push_back(32'h11);
    check("t5_dataout_old", ep_dataout, 32'h11);
    commit(); exp_q.push_back(32'h22);
    check("t5_dataout_new", ep_dataout, 32'h22);
    check("t5_count", 32'(q_count), 32'd2);
    drain("t5_drain");

    // 6: identical re-commit, then reset mid-stream
    wr(EP, 32'h5); commit(); exp_q.push_back(32'h5);
    wr(EP, 32'h5); commit();
`ifdef WIRE_IN_CHANGE_ONLY_EN
    check("t6_count", 32'(q_count), 32'd1);
`else
    exp_q.push_back(32'h5);
    check("t6_count", 32'(q_count), 32'd2);
`endif
    check("t6_dataout", ep_dataout, 32'h5);
    #2;
    ti_reset = 1'b1;
    #1;
    exp_q.delete();
    check("t6_rst_count", 32'(q_count), 32'd0);
    check("t6_rst_valid", 32'(bus.q_valid), 32'd0);
    check("t6_rst_dataout", ep_dataout, 32'h0);
    @(negedge ti_clk);
    ti_reset = 1'b0;
    tick();
    wr(EP, 32'h77); commit(); exp_q.push_back(32'h77);
    check("t6_post_dataout", ep_dataout, 32'h77);
    check("t6_post_count", 32'(q_count), 32'd1);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
